// File: rtl/kernel_pkg.sv
// Shared definitions for the 3x3 kernel filter: mode codes, tap positions
// and the clamp helpers used when normalising a channel result.
package kernel_pkg;

   typedef enum logic [2:0] {
      MODE_PASS  = 3'd0,
      MODE_BOX   = 3'd1,
      MODE_SOBX  = 3'd2,
      MODE_SOBY  = 3'd3,
      MODE_SHARP = 3'd4,
      MODE_DIFF  = 3'd5,
      MODE_RSV6  = 3'd6,
      MODE_RSV7  = 3'd7
   } mode_e;

   localparam int N_TAPS = 9;

   // Row-major tap positions, k=0 top-left, k=4 centre.
   localparam int TAP_TL = 0;
   localparam int TAP_T  = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_L  = 3;
   localparam int TAP_C  = 4;
   localparam int TAP_R  = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_B  = 7;
   localparam int TAP_BR = 8;

   // Headroom bits above CH_W carried by the S1 sums.
   localparam int SUM_XW = 4;

   function automatic int sat_val(input int x, input int max_v);
      if (x < 0)
         return 0;
      else if (x > max_v)
         return max_v;
      else
         return x;
   endfunction

   function automatic logic sat_flag(input int x, input int max_v);
      return (x < 0) || (x > max_v);
   endfunction

   function automatic int abs_int(input int x);
      return (x < 0) ? -x : x;
   endfunction

endpackage

// File: rtl/kernel_filter_pipe_chan.sv
// One colour channel of the kernel engine: S1 forms the signed kernel sum,
// S2 normalises it (divide, abs, clamp) into a CH_W pixel plus clamp flag.
module kernel_chan
   import kernel_pkg::*;
#(
   parameter int CH_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  mode_e                  i_mode,
   input  mode_e                  i_s1_mode,
   input  logic [N_TAPS*CH_W-1:0] i_taps,
   output logic [CH_W-1:0]        o_pix,
   output logic                   o_clamp
);

   localparam int SUM_W = CH_W + SUM_XW;
   localparam int MAX_V = (1 << CH_W) - 1;

   logic signed [SUM_W-1:0] w_tap [N_TAPS];
   logic signed [SUM_W-1:0] w_sum;
   logic signed [SUM_W-1:0] r_sum;
   logic [CH_W-1:0]         w_box;
   int                      w_raw;
   int                      w_abs;
   logic [CH_W-1:0]         w_pix;
   logic                    w_clamp;
   logic [CH_W-1:0]         r_pix;
   logic                    r_clamp;

   generate
      for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
         assign w_tap[gi] = $signed({{SUM_XW{1'b0}}, i_taps[gi*CH_W +: CH_W]});
      end
   endgenerate

   always_comb begin
      w_sum = '0;
      case (i_mode)
         MODE_PASS:  w_sum = w_tap[TAP_C];
         MODE_BOX: begin
            for (int k = 0; k < N_TAPS; k++)
               w_sum = w_sum + w_tap[k];
         end
         MODE_SOBX:  w_sum = (w_tap[TAP_TL] + (w_tap[TAP_L] <<< 1) + w_tap[TAP_BL])
                           - (w_tap[TAP_TR] + (w_tap[TAP_R] <<< 1) + w_tap[TAP_BR]);
         MODE_SOBY:  w_sum = (w_tap[TAP_TL] + (w_tap[TAP_T] <<< 1) + w_tap[TAP_TR])
                           - (w_tap[TAP_BL] + (w_tap[TAP_B] <<< 1) + w_tap[TAP_BR]);
         MODE_SHARP: w_sum = (w_tap[TAP_C] <<< 2) + w_tap[TAP_C]
                           - w_tap[TAP_T] - w_tap[TAP_L] - w_tap[TAP_R] - w_tap[TAP_B];
         MODE_DIFF:  w_sum = w_tap[TAP_BL] - w_tap[TAP_BR];
         default:    w_sum = '0;
      endcase
   end

   // The box sum (up to 9*M) only fits as unsigned, so it is reinterpreted here.
   always_comb begin
      w_box   = CH_W'($unsigned(r_sum) / SUM_W'(9));
      w_raw   = int'(r_sum);
      w_abs   = abs_int(w_raw);
      w_pix   = '0;
      w_clamp = 1'b0;
      case (i_s1_mode)
         MODE_PASS:  w_pix = r_sum[CH_W-1:0];
         MODE_BOX:   w_pix = w_box;
         MODE_SOBX, MODE_SOBY, MODE_DIFF: begin
            w_pix   = CH_W'(sat_val(w_abs, MAX_V));
            w_clamp = sat_flag(w_abs, MAX_V);
         end
         MODE_SHARP: begin
            w_pix   = CH_W'(sat_val(w_raw, MAX_V));
            w_clamp = sat_flag(w_raw, MAX_V);
         end
         default:    w_clamp = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum   <= '0;
         r_pix   <= '0;
         r_clamp <= 1'b0;
      end else if (i_en) begin
         r_sum   <= w_sum;
         r_pix   <= w_pix;
         r_clamp <= w_clamp;
      end
   end

   assign o_pix   = r_pix;
   assign o_clamp = r_clamp;

endmodule

// File: rtl/kernel_filter_pipe.sv
// Two-stage 3x3 kernel engine over a valid/ready stream with per-beat mode
// capture, saturation reporting and a sticky saturation event counter.
module kernel_filter_pipe
   import kernel_pkg::*;
#(
   parameter int CH_W  = 8,
   parameter int N_CH  = 3,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2:0]                    mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_TAPS*N_CH*CH_W-1:0]   window,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_CH*CH_W-1:0]          pixel_out,
   output logic                          out_sat,
   output logic [CNT_W-1:0]              sat_cnt,
   input  logic                          clr_cnt
);

   logic             w_en;
   logic             w_xfer;
   logic [N_CH-1:0]  w_clamp;
   logic             r_s1_valid;
   logic             r_s2_valid;
   mode_e            r_s1_mode;
   logic [CNT_W-1:0] r_sat_cnt;

   // A single enable stalls the whole pipe, so at most two beats are held.
   assign w_en      = out_ready | ~r_s2_valid;
   assign in_ready  = w_en;
   assign out_valid = r_s2_valid;
   assign out_sat   = |w_clamp;
   assign w_xfer    = r_s2_valid & out_ready;
   assign sat_cnt   = r_sat_cnt;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [N_TAPS*CH_W-1:0] w_taps;
         for (genvar gk = 0; gk < N_TAPS; gk++) begin : g_tap
            assign w_taps[gk*CH_W +: CH_W] = window[(gk*N_CH + gi)*CH_W +: CH_W];
         end
         kernel_chan #(
            .CH_W(CH_W)
         ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_en     (w_en),
            .i_mode   (mode_e'(mode)),
            .i_s1_mode(r_s1_mode),
            .i_taps   (w_taps),
            .o_pix    (pixel_out[gi*CH_W +: CH_W]),
            .o_clamp  (w_clamp[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_mode  <= MODE_PASS;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         r_s2_valid <= r_s1_valid;
         r_s1_mode  <= mode_e'(mode);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sat_cnt <= '0;
      else if (clr_cnt)
         r_sat_cnt <= '0;
      else if (w_xfer && out_sat && (r_sat_cnt != '1))
         r_sat_cnt <= r_sat_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_kernel_filter_pipe.sv
// Directed bench for kernel_filter_pipe: literal checks per scenario plus a
// negedge monitor comparing every output beat against an arithmetic model.
module tb_kernel_filter_pipe;

   localparam int CH_W  = 8;
   localparam int N_CH  = 3;
   localparam int PIX_W = N_CH * CH_W;
   localparam int WIN_W = 9 * PIX_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       mode = 3'd0;
   logic             in_valid = 1'b0;
   logic [WIN_W-1:0] window = '0;
   logic             out_ready = 1'b1;
   logic             clr_cnt = 1'b0;

   logic             in_ready, out_valid, out_sat;
   logic [PIX_W-1:0] pixel_out;
   logic [15:0]      sat_cnt;
   logic             in_ready4, out_valid4, out_sat4;
   logic [PIX_W-1:0] pixel_out4;
   logic [3:0]       sat_cnt4;

   kernel_filter_pipe #(.CH_W(CH_W), .N_CH(N_CH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .window(window), .out_valid(out_valid), .out_ready(out_ready),
      .pixel_out(pixel_out), .out_sat(out_sat), .sat_cnt(sat_cnt), .clr_cnt(clr_cnt)
   );

   kernel_filter_pipe #(.CH_W(CH_W), .N_CH(N_CH), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready4),
      .window(window), .out_valid(out_valid4), .out_ready(out_ready),
      .pixel_out(pixel_out4), .out_sat(out_sat4), .sat_cnt(sat_cnt4), .clr_cnt(clr_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [WIN_W-1:0] put(input logic [WIN_W-1:0] w, input int k,
                                            input int c, input int v);
      w[(k*N_CH + c)*CH_W +: CH_W] = v[7:0];
      return w;
   endfunction

   // Model: returns {sat, pixel} from the kernel definitions with plain ints.
   function automatic logic [PIX_W:0] model(input logic [WIN_W-1:0] w, input logic [2:0] m);
      logic [PIX_W-1:0] pix;
      logic             sat;
      int               t [9];
      int               v;
      pix = '0;
      sat = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         for (int k = 0; k < 9; k++)
            t[k] = int'(w[(k*N_CH + c)*CH_W +: CH_W]);
         v = 0;
         case (m)
            3'd0: v = t[4];
            3'd1: v = (t[0]+t[1]+t[2]+t[3]+t[4]+t[5]+t[6]+t[7]+t[8]) / 9;
            3'd2: begin
               v = (t[0] + 2*t[3] + t[6]) - (t[2] + 2*t[5] + t[8]);
               if (v < 0) v = -v;
            end
            3'd3: begin
               v = (t[0] + 2*t[1] + t[2]) - (t[6] + 2*t[7] + t[8]);
               if (v < 0) v = -v;
            end
            3'd4: v = 5*t[4] - t[1] - t[3] - t[5] - t[7];
            3'd5: begin
               v = t[6] - t[8];
               if (v < 0) v = -v;
            end
            default: sat = 1'b1;
         endcase
         if (v > 255) begin v = 255; sat = 1'b1; end
         if (v < 0)   begin v = 0;   sat = 1'b1; end
         pix[c*CH_W +: CH_W] = v[7:0];
      end
      return {sat, pix};
   endfunction

   logic [PIX_W:0] q [$];
   int m_cnt  = 0;
   int m_cnt4 = 0;

   always @(negedge clk) begin
      logic [PIX_W:0] e;
      if (rst) begin
         q.delete();
         m_cnt  = 0;
         m_cnt4 = 0;
         chk("mon_rst_valid", out_valid, 0);
         chk("mon_rst_cnt", sat_cnt, 0);
         chk("mon_rst_cnt4", sat_cnt4, 0);
      end else begin
         chk("mon_sat_cnt", sat_cnt, m_cnt);
         chk("mon_sat_cnt4", sat_cnt4, m_cnt4);
         if (q.size() == 0) begin
            chk("mon_idle_valid", out_valid, 0);
         end else if (out_valid) begin
            e = q[0];
            chk("mon_pixel", pixel_out, e[PIX_W-1:0]);
            chk("mon_sat", out_sat, e[PIX_W]);
            chk("mon_pixel4", pixel_out4, e[PIX_W-1:0]);
            if (out_ready) begin
               void'(q.pop_front());
               if (e[PIX_W] && !clr_cnt) begin
                  if (m_cnt < 65535) m_cnt++;
                  if (m_cnt4 < 15)   m_cnt4++;
               end
            end
         end
         if (clr_cnt) begin
            m_cnt  = 0;
            m_cnt4 = 0;
         end
         if (in_valid && in_ready)
            q.push_back(model(window, mode));
      end
   end

   // Called 1 time unit after a rising edge; leaves the beat sitting on the output.
   task automatic run_one(input string name, input logic [2:0] m, input logic [WIN_W-1:0] w,
                          input logic [PIX_W-1:0] exp_pix, input logic exp_sat);
      mode      = m;
      window    = w;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      window   = '0;
      mode     = 3'd0;
      chk({name, "_lat1_valid"}, out_valid, 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_pix"}, pixel_out, exp_pix);
      chk({name, "_sat"}, out_sat, exp_sat);
      $display("beat %s mode=%0d pixel=%h sat=%0b", name, m, pixel_out, out_sat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [WIN_W-1:0] w;
      logic [WIN_W-1:0] w_bp;

      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_pixel", pixel_out, 0);
      chk("reset_sat", out_sat, 0);
      chk("reset_cnt", sat_cnt, 0);

      w = '0; w[4*PIX_W +: PIX_W] = 24'h123456;
      run_one("pass", 3'd0, w, 24'h123456, 1'b0);

      w = '0;
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = 24'hFF8008;
      run_one("box_uniform", 3'd1, w, 24'hFF8008, 1'b0);

      w = '0;
      for (int k = 0; k < 9; k++) w = put(w, k, 0, k);
      run_one("box_0to8", 3'd1, w, 24'h000004, 1'b0);

      w = '0;
      for (int k = 0; k < 8; k++) w = put(w, k, 0, k + 1);
      run_one("box_1to8", 3'd1, w, 24'h000004, 1'b0);

      w = '0;
      for (int k = 0; k < 8; k++) w = put(w, k, 0, k);
      w = put(w, 8, 0, 16);
      run_one("box_sum44", 3'd1, w, 24'h000004, 1'b0);

      w = '0; w = put(w, 0, 0, 255); w = put(w, 3, 0, 255); w = put(w, 6, 0, 255);
      run_one("sobx_left", 3'd2, w, 24'h0000FF, 1'b1);
      @(posedge clk); #1;
      chk("sobx_cnt1", sat_cnt, 1);

      w = '0; w = put(w, 2, 0, 255); w = put(w, 5, 0, 255); w = put(w, 8, 0, 255);
      run_one("sobx_right", 3'd2, w, 24'h0000FF, 1'b1);

      w = '0; w = put(w, 0, 1, 10); w = put(w, 1, 1, 10); w = put(w, 2, 1, 10);
      run_one("soby_top", 3'd3, w, 24'h002800, 1'b0);

      w = '0; w = put(w, 6, 2, 5); w = put(w, 8, 2, 200);
      run_one("diff", 3'd5, w, 24'hC30000, 1'b0);

      w = '0; w = put(w, 4, 0, 16);
      w = put(w, 1, 0, 32); w = put(w, 3, 0, 32); w = put(w, 5, 0, 32); w = put(w, 7, 0, 32);
      run_one("sharp_neg", 3'd4, w, 24'h000000, 1'b1);

      w = '0;
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = 24'hFF8008;
      run_one("rsv6", 3'd6, w, 24'h000000, 1'b1);
      @(posedge clk); #1;
      chk("cnt_after_directed", sat_cnt, 4);

      // Backpressure: three beats, distinct modes, same window.
      w_bp = '0;
      for (int k = 0; k < 9; k++) begin
         w_bp = put(w_bp, k, 0, 10*k);
         w_bp = put(w_bp, k, 1, 3 + k);
         w_bp = put(w_bp, k, 2, 200);
      end
      out_ready = 1'b0;
      window    = w_bp;
      mode      = 3'd0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      mode = 3'd5;
      @(posedge clk); #1;
      mode = 3'd3;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_hold_pix", pixel_out, 24'hC80728);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_first", pixel_out, 24'hC80728);
      chk("bp_in_ready_back", in_ready, 1);
      $display("beat bp_first pixel=%h", pixel_out);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second", pixel_out, 24'h000214);
      $display("beat bp_second pixel=%h", pixel_out);
      @(posedge clk); #1;
      chk("bp_third", pixel_out, 24'h0018F0);
      $display("beat bp_third pixel=%h", pixel_out);
      @(posedge clk); #1;
      chk("bp_drained", out_valid, 0);

      // Clear coincident with a saturated transfer.
      run_one("rsv7_clr", 3'd7, w_bp, 24'h000000, 1'b1);
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      chk("clr_priority", sat_cnt, 0);

      // Twenty saturated beats: the 4-bit counter must stick at 0xF.
      mode      = 3'd6;
      window    = w_bp;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt16_after20", sat_cnt, 20);
      chk("cnt4_stuck", sat_cnt4, 4'hF);
      $display("beat stream20 sat_cnt=%0d sat_cnt4=%0d", sat_cnt, sat_cnt4);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      mode      = 3'd0;
      window    = w_bp;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_pixel", pixel_out, 0);
      chk("rst_async_cnt", sat_cnt, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         chk("post_rst_idle", out_valid, 0);
      end

      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/kernel_filter_pipe.md
Name: kernel_filter_pipe

Overview:
Parametrised, pipelined 3x3 image kernel engine. Takes one 9-tap pixel window per beat (N_CH channels of CH_W bits each), applies a mode-selected kernel per channel, and emits one filtered pixel per beat over a valid/ready stream. It sits between the window/line-buffer stage and the video output path, and replaces the fixed 24-bit, switch-driven kernel block. It adds clamping with saturation reporting, per-beat mode capture and backpressure.

Parameters:
CH_W, 8, bits per colour channel
N_CH, 3, channels per pixel
CNT_W, 16, width of the saturation event counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode  in  3  kernel select, sampled with each accepted input beat
in_valid  in  1  window beat valid
in_ready  out  1  block can accept a beat
window  in  9*N_CH*CH_W  taps k=0..8 row-major (k=0 top-left, k=4 centre); tap k at bits [k*N_CH*CH_W +: N_CH*CH_W]; channel c at [c*CH_W +: CH_W] within a tap
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
pixel_out  out  N_CH*CH_W  filtered pixel, same channel packing as the input
out_sat  out  1  some channel of this beat was clamped, or the mode was reserved
sat_cnt  out  CNT_W  count of transferred beats with out_sat=1
clr_cnt  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset is asynchronous and active-high. During reset: out_valid=0, pixel_out=0, out_sat=0, sat_cnt=0, and all internal stage valids=0. Asserting rst mid-stream drops every in-flight beat; none emerges after release.
- Two register stages. S1 holds per-channel signed sums and the mode. S2 holds the normalised, clamped pixel.
- Latency is 2 cycles from input handshake to out_valid when out_ready=1. Throughput is 1 beat/cycle.
- Global advance: en = out_ready | ~out_valid, and in_ready = en. When en=1, every stage shifts and a stage's valid takes the previous stage's valid.
- While out_valid=1 and out_ready=0, pixel_out, out_sat and out_valid hold stable. The block holds at most 2 beats.
- Input is accepted on in_valid & in_ready. An output transfer is out_valid & out_ready.
- Modes, per channel; M = 2^CH_W-1; sat(x) clamps to [0,M] and flags if a clamp occurred:
  - 0 pass: w4.
  - 1 box: floor((w0+...+w8)/9). Exact integer result; no flag is possible.
  - 2 sobel-x: sat(|(w0+2w3+w6)-(w2+2w5+w8)|).
  - 3 sobel-y: sat(|(w0+2w1+w2)-(w6+2w7+w8)|).
  - 4 sharpen: sat(5*w4-w1-w3-w5-w7), with negative results clamped to 0.
  - 5 diff: sat(|w6-w8|).
  - 6,7 reserved: pixel 0, out_sat=1.
- Arithmetic width: S1 sums are signed with CH_W+4 bits. No intermediate wrap is allowed.
- out_sat is the OR of the per-channel clamp flags of that beat.
- sat_cnt increments on each transfer with out_sat=1 and saturates at all-ones (no wrap).
- clr_cnt has priority over a simultaneous increment: the counter becomes 0.
- The mode change takes effect on the next accepted beat. Beats already in flight keep their captured mode.

Decomposition:
- Shared package kernel_pkg:
  - mode constants MODE_PASS, MODE_BOX, MODE_SOBX, MODE_SOBY, MODE_SHARP, MODE_DIFF
  - N_TAPS=9 and tap index constants (TAP_C=4, etc.)
  - a function for sat/clamp
- Sub-module kernel_chan holds one channel's S1 combine and S2 normalise/clamp logic, instantiated N_CH times by generate.
- The handshake, valid pipeline and counter live in the top module.

Test Plan:
- Pass: mode=0, w4=0x123456, other taps 0, out_ready=1 -> 2 cycles later out_valid=1, pixel_out=0x123456, out_sat=0.
- Box: all taps 0xFF8008 -> 0xFF8008. Channel 0 taps holding 0..8 -> channel 0 out=4 (sum 36); taps 1..8 plus 0 give floor(36/9)=4; sum 44 -> 4.
- Sobel-x:
  - Stimulus: channel 0 left column 0xFF, right column 0; sat_cnt starts at 0 and out_ready=1.
  - Response: channel 0 out=0xFF, out_sat=1, sat_cnt=1 after the transfer.
  - Mirrored stimulus -> identical result.
- Sharpen: centre 0x10, w1/w3/w5/w7=0x20 -> 80-128 clamps to 0, out_sat=1. Mode 6 -> pixel 0, out_sat=1.
- Backpressure: send 3 beats with out_ready=0 -> the first 2 are accepted, then in_ready=0. Hold for 5 cycles; outputs are stable. Release -> 3 beats come out in order, no duplicates, mode captured per beat.
- Reset/counter:
  - rst pulse with 2 beats in flight -> out_valid=0 asynchronously; nothing appears after release.
  - clr_cnt coincident with a saturated transfer -> sat_cnt=0.
  - Counter preset near the limit (CNT_W=4 build) sticks at 0xF.
